// File: rtl/fp_to_int_converter.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int_converter
// Purpose  : Multi-cycle IEEE-754 single-precision to signed int32 converter.
//            The mantissa is aligned by a one-bit-per-cycle shifter, then
//            optionally rounded, negated and saturated.
// Ports    : clk      in   rising-edge clock
//            rst      in   asynchronous active-high reset
//            start    in   request a conversion of a (sampled in IDLE only)
//            a        in   [31:0] single-precision operand
//            busy     out  conversion in progress (any state but IDLE)
//            done     out  one-cycle pulse, result/flags valid
//            result   out  [31:0] two's-complement integer
//            overflow out  magnitude outside int32, result saturated
//            invalid  out  operand was NaN or Inf
// Options  : FP2INT_ROUND_EN defined   -> round to nearest even
//            FP2INT_ROUND_EN undefined -> truncate toward zero
// Revision : 1.0  initial release
// ============================================================================
module fp_to_int_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SHIFT  = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] c_pos_sat  = 32'h7FFF_FFFF;
  localparam logic [31:0] c_neg_sat  = 32'h8000_0000;
  localparam logic [7:0]  c_exp_ovf  = 8'd158;
  localparam logic [7:0]  c_exp_unit = 8'd150;
`ifdef FP2INT_ROUND_EN
  // 0.5 <= |x| < 1 can round up to 1, so e=126 takes the shift path.
  localparam logic [7:0]  c_exp_min  = 8'd126;
`else
  localparam logic [7:0]  c_exp_min  = 8'd127;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_mag;
  logic [4:0]  r_n;
  logic        r_left;
  logic [31:0] r_result;
  logic        r_overflow;
  logic        r_invalid;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic        w_is_special;
  logic        w_is_small;
  logic        w_is_ovf;
  logic        w_is_int_min;
  logic        w_left;
  logic [4:0]  w_shift_n;
  logic [31:0] w_mag_rnd;

  assign w_sign       = r_a[31];
  assign w_exp        = r_a[30:23];
  assign w_mant       = r_a[22:0];
  assign w_is_special = (w_exp == 8'hFF);
  assign w_is_small   = (w_exp < c_exp_min);
  assign w_is_ovf     = (w_exp >= c_exp_ovf);
  // -2^31 is representable even though its exponent is the saturating one.
  assign w_is_int_min = (r_a == 32'hCF00_0000);
  assign w_left       = (w_exp > c_exp_unit);
  // On the shift path e is 126..157, so |e-150| fits in 5 bits and only the
  // low exponent bits matter (150 mod 32 = 22).
  assign w_shift_n    = w_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);

`ifdef FP2INT_ROUND_EN
  logic r_guard;
  logic r_sticky;
  logic w_round_up;
  // Round half to even: bump when above half, or exactly half and odd.
  assign w_round_up = r_guard & (r_sticky | r_mag[0]);
  assign w_mag_rnd  = r_mag + {31'd0, w_round_up};
`else
  assign w_mag_rnd  = r_mag;
`endif

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign overflow = r_overflow;
  assign invalid  = r_invalid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_is_special || w_is_small || w_is_ovf) w_next = S_DONE;
        else if (w_shift_n == 5'd0)                 w_next = S_FINISH;
        else                                        w_next = S_SHIFT;
      end
      S_SHIFT:  if (r_n == 5'd1) w_next = S_FINISH;
      S_FINISH: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= 32'd0;
      r_mag      <= 32'd0;
      r_n        <= 5'd0;
      r_left     <= 1'b0;
      r_result   <= 32'd0;
      r_overflow <= 1'b0;
      r_invalid  <= 1'b0;
`ifdef FP2INT_ROUND_EN
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= a;
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
`ifdef FP2INT_ROUND_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
          end
        end
        S_CHECK: begin
          if (w_is_special) begin
            r_invalid <= 1'b1;
            // Only -Inf saturates negative; any NaN maps to the positive limit.
            r_result  <= (w_sign && (w_mant == 23'd0)) ? c_neg_sat : c_pos_sat;
          end else if (w_is_small) begin
            r_result <= 32'd0;
          end else if (w_is_ovf) begin
            if (w_is_int_min) begin
              r_result <= c_neg_sat;
            end else begin
              r_overflow <= 1'b1;
              r_result   <= w_sign ? c_neg_sat : c_pos_sat;
            end
          end else begin
            r_mag  <= {8'd0, 1'b1, w_mant};
            r_n    <= w_shift_n;
            r_left <= w_left;
          end
        end
        S_SHIFT: begin
          r_n <= r_n - 5'd1;
          if (r_left) begin
            r_mag <= {r_mag[30:0], 1'b0};
          end else begin
            r_mag <= {1'b0, r_mag[31:1]};
`ifdef FP2INT_ROUND_EN
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
`endif
          end
        end
        S_FINISH: begin
          r_result <= w_sign ? (~w_mag_rnd + 32'd1) : w_mag_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_int_converter
// Purpose  : Scoreboard bench for fp_to_int_converter. Expected results come
//            from an integer-arithmetic model of float-to-int conversion.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  always #5 clk = ~clk;

  fp_to_int_converter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .invalid  (invalid)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef FP2INT_ROUND_EN
  localparam int EMIN = 126;
`else
  localparam int EMIN = 127;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value = m * 2^(e-150); convert with integer quotient/remainder, then clamp.
  function automatic exp_t model(input logic [31:0] op);
    exp_t   x;
    int     e;
    bit     s;
    longint m, mag, q, v;
`ifdef FP2INT_ROUND_EN
    longint rem, half;
`endif
    s = op[31];
    e = int'(op[30:23]);
    m = longint'({1'b1, op[22:0]});
    x.op = op; x.ovf = 1'b0; x.inv = 1'b0; x.t0 = 0; x.res = 32'd0; x.lat = 2;
    if (e == 255) begin
      x.inv = 1'b1;
      x.res = (s && op[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < EMIN) begin
      x.res = 32'd0;
    end else if (e > 158) begin
      x.ovf = 1'b1;
      x.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      if (e >= 150) begin
        mag = m << (e - 150);
      end else begin
        q   = m >> (150 - e);
        mag = q;
`ifdef FP2INT_ROUND_EN
        rem  = m - (q << (150 - e));
        half = 64'sd1 << (149 - e);
        if (rem > half || (rem == half && q[0])) mag = q + 1;
`endif
      end
      v = s ? -mag : mag;
      if (v > 64'sd2147483647) begin
        x.ovf = 1'b1; x.res = 32'h7FFF_FFFF;
      end else if (v < -64'sd2147483648) begin
        x.ovf = 1'b1; x.res = 32'h8000_0000;
      end else begin
        x.res = v[31:0];
      end
      x.lat = (e >= 158) ? 2 : ((e > 150) ? e - 150 : 150 - e) + 3;
    end
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got result %0h with no pending request", result);
        end else begin
          x = sbq.pop_front();
          chk($sformatf("result[%h]", x.op),   64'(result),   64'(x.res));
          chk($sformatf("overflow[%h]", x.op), 64'(overflow), 64'(x.ovf));
          chk($sformatf("invalid[%h]", x.op),  64'(invalid),  64'(x.inv));
          chk($sformatf("latency[%h]", x.op),  64'(cyc - x.t0 + 1), 64'(x.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL timeout: busy got %b expected 0 within 64 cycles", busy);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic conv(input logic [31:0] op, input bit poke_busy);
    exp_t x;
    x = model(op);
    x.t0 = cyc + 1;
    a = op; start = 1'b1;
    sbq.push_back(x);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (poke_busy) begin
      repeat (2) @(negedge clk);
      a = 32'h4F00_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    chk("hold_result", 64'(result), 64'(x.res));
    chk("hold_ovf",    64'(overflow), 64'(x.ovf));
    chk("hold_inv",    64'(invalid), 64'(x.inv));
  endtask

  initial begin
    logic [31:0] op;
    exp_t        x;
    rst = 1'b1; start = 1'b0; a = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy",     64'(busy),     64'd0);
    chk("reset_done",     64'(done),     64'd0);
    chk("reset_result",   64'(result),   64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_invalid",  64'(invalid),  64'd0);
    rst = 1'b0;

    conv(32'h4049_0FDB, 1'b0);  // 3.14159 -> 3, 25 edges
    conv(32'hC2F6_E979, 1'b0);  // -123.456
    conv(32'h4F00_0000, 1'b0);
    conv(32'hCF00_0000, 1'b0);
    conv(32'h7FC0_0000, 1'b0);
    conv(32'hFF80_0000, 1'b0);
    conv(32'h7F80_0000, 1'b0);
    conv(32'h3FC0_0000, 1'b0);  // 1.5
    conv(32'h4020_0000, 1'b0);  // 2.5
    conv(32'h3F00_0000, 1'b0);  // 0.5
    conv(32'h8000_0000, 1'b0);  // -0
    conv(32'h0000_0001, 1'b0);  // denormal
    conv(32'h4B00_0000, 1'b0);  // 2^23, N=0 path
    conv(32'h4EFF_FFFF, 1'b0);  // largest in-range
    conv(32'hCEFF_FFFF, 1'b0);
    conv(32'h3F80_0001, 1'b1);  // start while busy is ignored

    // Reset in the middle of SHIFT.
    x = model(32'h3F80_0001);
    x.t0 = cyc + 1;
    a = 32'h3F80_0001; start = 1'b1;
    sbq.push_back(x);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midshift_rst_busy",   64'(busy),   64'd0);
    chk("midshift_rst_done",   64'(done),   64'd0);
    chk("midshift_rst_result", 64'(result), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    conv(32'h3F80_0001, 1'b0);  // accepted on the first edge after release
    conv(32'hBFC0_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom;
      if (i % 2 == 0) op[30:23] = 8'($urandom_range(120, 160));
      conv(op, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
